// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding, opcode map and decoded control bundle
// for the ctrl_seq instruction sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  // instr[8:6]
  localparam logic [2:0] OP_ALU0 = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_SB   = 3'b010;
  localparam logic [2:0] OP_LBU  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_SRL  = 3'b111;

  // instr[5:4] when opcode is OP_ALU0
  localparam logic [1:0] SUB_MOV  = 2'b00;
  localparam logic [1:0] SUB_ADD  = 2'b01;
  localparam logic [1:0] SUB_LI   = 2'b10;
  localparam logic [1:0] SUB_HALT = 2'b11;

  typedef struct packed {
    logic is_alu;     // any op that goes through the ALU, LI included
    logic is_li;
    logic is_srl;
    logic is_beq;
    logic is_mem_rd;  // LBU
    logic is_mem_wr;  // SB
    logic is_halt;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/sub-op to control bundle decoder.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] subop,
  output ctrl_t      ctl
);

  // Pure decode of the instruction class
  always_comb begin
    ctl           = '0;
    ctl.is_halt   = (opcode == OP_ALU0) && (subop == SUB_HALT);
    ctl.is_li     = (opcode == OP_ALU0) && (subop == SUB_LI);
    ctl.is_alu    = ((opcode == OP_ALU0) && (subop != SUB_HALT)) ||
                    (opcode == OP_XOR) || (opcode == OP_OR) ||
                    (opcode == OP_AND) || (opcode == OP_SRL);
    ctl.is_srl    = (opcode == OP_SRL);
    ctl.is_beq    = (opcode == OP_BEQ);
    ctl.is_mem_rd = (opcode == OP_LBU);
    ctl.is_mem_wr = (opcode == OP_SB);
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit
// datapath. Optional retired-instruction counter enabled by CTRL_ICOUNT_EN.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int INST_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] instr,
  output logic [6:0]        alu_cmd,
  output logic              ALUSrc,
  output logic              li,
  output logic [7:0]        imm,
  output logic [1:0]        rd_addr,
  output logic [1:0]        rs_addr,
  output logic              reg_wen,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic              alu_zero,
  input  logic              alu_sc,
  output logic              sc_q
`ifdef CTRL_ICOUNT_EN
  ,
  output logic [15:0]       icount
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [INST_W-1:0] r_ir;
  logic [INST_W-1:0] w_src;
  ctrl_t             w_ctl;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_boff;
  logic              r_zero_q;
  logic              r_sc_q;
  logic              r_start_d;
  logic              w_restart;

  // ir is only loaded at the end of DECODE, so DECODE itself looks at the
  // live imem data; later states use the latched copy.
  assign w_src     = (r_state == ST_DECODE) ? instr : r_ir;
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_boff    = {{(PC_W-6){r_ir[5]}}, r_ir[5:0]};
  assign w_restart = start && !r_start_d;
  assign pc        = r_pc;
  assign sc_q      = r_sc_q;

  ctrl_decode u_decode (
    .opcode (w_src[8:6]),
    .subop  (w_src[5:4]),
    .ctl    (w_ctl)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and per-state control outputs
  always_comb begin
    w_next  = r_state;
    alu_cmd = '0;
    imm     = '0;
    rd_addr = '0;
    rs_addr = '0;
    ALUSrc  = 1'b0;
    li      = 1'b0;
    reg_wen = 1'b0;
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    done    = 1'b0;
    if (r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
      alu_cmd = {w_src[8:6], w_src[5:2]};
      imm     = {4'h0, w_src[3:0]};
      rd_addr = w_src[3:2];
      rs_addr = w_src[1:0];
    end
    unique case (r_state)
      ST_IDLE:   if (start) w_next = ST_FETCH;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = w_ctl.is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        ALUSrc = w_ctl.is_li;
        li     = w_ctl.is_li;
        if (w_ctl.is_beq)                           w_next = ST_FETCH;
        else if (w_ctl.is_mem_rd || w_ctl.is_mem_wr) w_next = ST_MEM;
        else                                        w_next = ST_WB;
      end
      ST_MEM: begin
        mem_ren = w_ctl.is_mem_rd;
        mem_wen = w_ctl.is_mem_wr;
        w_next  = w_ctl.is_mem_wr ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        reg_wen = 1'b1;
        w_next  = ST_FETCH;
      end
      ST_HALT: begin
        done = 1'b1;
        if (w_restart) w_next = ST_FETCH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // PC, instruction register and ALU flag capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_zero_q  <= 1'b0;
      r_sc_q    <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= start;
      case (r_state)
        ST_IDLE:   if (start) r_pc <= '0;
        ST_DECODE: r_ir <= instr;
        ST_EXEC: begin
          if (w_ctl.is_alu) r_zero_q <= alu_zero;
          if (w_ctl.is_srl) r_sc_q   <= alu_sc;
          if (w_ctl.is_beq) r_pc     <= r_zero_q ? (r_pc + w_boff) : w_pc_inc;
        end
        // SB has no WB stage, so it advances the PC here
        ST_MEM:    if (w_ctl.is_mem_wr) r_pc <= w_pc_inc;
        ST_WB:     r_pc <= w_pc_inc;
        ST_HALT:   if (w_restart) r_pc <= '0;
        default: ;
      endcase
    end
  end

`ifdef CTRL_ICOUNT_EN
  logic [15:0] r_icount;
  logic        w_retire;
  logic        w_launch;

  // An instruction retires whenever an active instruction state hands off
  // to FETCH or HALT; a launch is leaving IDLE/HALT for FETCH.
  assign w_retire = (r_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) &&
                    (w_next inside {ST_FETCH, ST_HALT});
  assign w_launch = (r_state inside {ST_IDLE, ST_HALT}) && (w_next == ST_FETCH);
  assign icount   = r_icount;

  // Saturating retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset || w_launch)             r_icount <= '0;
    else if (w_retire && r_icount != '1) r_icount <= r_icount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed plus randomized bench for ctrl_seq against an
// instruction-level reference model (latency table per instruction class).
// Build with +define+CTRL_ICOUNT_EN to also check icount.
module tb_ctrl_seq;

  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            done;
  logic [PC_W-1:0] pc;
  logic [8:0]      instr = '0;
  logic [6:0]      alu_cmd;
  logic            ALUSrc, li;
  logic [7:0]      imm;
  logic [1:0]      rd_addr, rs_addr;
  logic            reg_wen, mem_ren, mem_wen;
  logic            alu_zero = 1'b0;
  logic            alu_sc = 1'b0;
  logic            sc_q;
`ifdef CTRL_ICOUNT_EN
  logic [15:0]     icount;
`endif

  ctrl_seq #(.PC_W(PC_W), .INST_W(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .pc       (pc),
    .instr    (instr),
    .alu_cmd  (alu_cmd),
    .ALUSrc   (ALUSrc),
    .li       (li),
    .imm      (imm),
    .rd_addr  (rd_addr),
    .rs_addr  (rs_addr),
    .reg_wen  (reg_wen),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .alu_zero (alu_zero),
    .alu_sc   (alu_sc),
    .sc_q     (sc_q)
`ifdef CTRL_ICOUNT_EN
    ,
    .icount   (icount)
`endif
  );

  always #5 clk = ~clk;

  // synchronous instruction memory
  logic [8:0] mem [0:(1<<PC_W)-1];
  always @(posedge clk) instr <= mem[pc];

  int vecs = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int cnt_rwen = 0, cnt_ren = 0, cnt_wen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ilen(input logic [8:0] c);
    case (c[8:6])
      3'b000:  ilen = (c[5:4] == 2'b11) ? 2 : 4;
      3'b001:  ilen = 3;
      3'b010:  ilen = 4;
      3'b011:  ilen = 5;
      default: ilen = 4;
    endcase
  endfunction

  function automatic bit writes_reg(input logic [8:0] c);
    writes_reg = !((c[8:6] == 3'b001) || (c[8:6] == 3'b010) ||
                   (c[8:6] == 3'b000 && c[5:4] == 2'b11));
  endfunction

  function automatic bit alu_op(input logic [8:0] c);
    alu_op = (c[8:6] == 3'b000 && c[5:4] != 2'b11) || c[8];
  endfunction

  int         m_mode;   // 0 idle, 1 running, 2 halted
  int         m_k;      // cycle index within current instruction
  logic [9:0] m_pc;
  logic [8:0] m_inst;
  bit         m_zero, m_sc, m_startd;
  int         m_icount;
  logic [8:0] m_ci;
  logic [9:0] m_off;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_k = 0; m_pc = '0; m_inst = '0;
      m_zero = 0; m_sc = 0; m_startd = 0; m_icount = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_pc = '0; m_k = 0; m_icount = 0; end
        1: begin
          m_ci = (m_k == 1) ? mem[m_pc] : m_inst;
          if (m_k == 1) m_inst = mem[m_pc];
          if (m_k == 2 && alu_op(m_ci)) begin
            m_zero = alu_zero;
            if (m_ci[8:6] == 3'b111) m_sc = alu_sc;
          end
          if (m_k >= 1 && m_k == ilen(m_ci) - 1) begin
            if (m_icount < 16'hFFFF) m_icount++;
            if (m_ci[8:6] == 3'b000 && m_ci[5:4] == 2'b11) begin
              m_mode = 2;
            end else if (m_ci[8:6] == 3'b001 && m_zero) begin
              m_off = {{4{m_ci[5]}}, m_ci[5:0]};
              m_pc  = m_pc + m_off;
            end else begin
              m_pc = m_pc + 10'd1;
            end
            m_k = 0;
          end else begin
            m_k++;
          end
        end
        default: if (start && !m_startd) begin m_mode = 1; m_pc = '0; m_k = 0; m_icount = 0; end
      endcase
      m_startd = start;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [8:0] e_ci;
  logic [6:0] e_cmd;
  logic [7:0] e_imm;
  logic [1:0] e_rd, e_rs;
  logic       e_src, e_rwen, e_ren, e_wen;

  always @(negedge clk) begin
    if (chk_en) begin
      e_cmd = '0; e_imm = '0; e_rd = '0; e_rs = '0;
      e_src = 0; e_rwen = 0; e_ren = 0; e_wen = 0;
      if (m_mode == 1 && m_k >= 1) begin
        e_ci  = (m_k == 1) ? mem[m_pc] : m_inst;
        e_cmd = e_ci[8:2];
        e_imm = {4'h0, e_ci[3:0]};
        e_rd  = e_ci[3:2];
        e_rs  = e_ci[1:0];
        e_src = (m_k == 2) && (e_ci[8:4] == 5'b00010);
        e_ren = (m_k == 3) && (e_ci[8:6] == 3'b011);
        e_wen = (m_k == 3) && (e_ci[8:6] == 3'b010);
        e_rwen = (m_k == ilen(e_ci) - 1) && writes_reg(e_ci);
      end
      chk("pc", pc, m_pc);
      chk("done", done, (m_mode == 2));
      chk("alu_cmd", alu_cmd, e_cmd);
      chk("imm", imm, e_imm);
      chk("rd_addr", rd_addr, e_rd);
      chk("rs_addr", rs_addr, e_rs);
      chk("ALUSrc", ALUSrc, e_src);
      chk("li", li, e_src);
      chk("reg_wen", reg_wen, e_rwen);
      chk("mem_ren", mem_ren, e_ren);
      chk("mem_wen", mem_wen, e_wen);
      chk("sc_q", sc_q, m_sc);
      chk("strobe_excl", (int'(reg_wen) + int'(mem_ren) + int'(mem_wen)) <= 1, 1);
`ifdef CTRL_ICOUNT_EN
      chk("icount", icount, m_icount);
`endif
      if (reg_wen) cnt_rwen++;
      if (mem_ren) cnt_ren++;
      if (mem_wen) cnt_wen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk("wait_done", done, 1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = 9'h030;
  endtask

  initial begin
    clear_mem();

    // reset in the middle of an ADD's EXEC
    mem[0] = 9'h010;
    do_reset();
    start = 1'b1;
    tick(); tick(); tick();
    chk("add_exec_cmd", alu_cmd, 7'h04);
    reset = 1'b1;
    tick();
    chk("rst_pc", pc, 0);
    chk("rst_reg_wen", reg_wen, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_cmd", alu_cmd, 0);
    reset = 1'b0;

    // LI r1,#5 then HALT
    clear_mem();
    mem[0] = 9'b000_10_0101;
    do_reset();
    start = 1'b1;
    tick(); tick(); tick();
    chk("li_alusrc", ALUSrc, 1);
    chk("li_li", li, 1);
    chk("li_imm", imm, 8'h05);
    tick();
    chk("li_wb_reg_wen", reg_wen, 1);
    tick();
    chk("li_after_wb_reg_wen", reg_wen, 0);
    chk("li_pc", pc, 1);
    wait_done(20);
    chk("li_halt_pc", pc, 1);

    // ADDs then BEQ +3 at pc 4, zero taken / not taken
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 9'h010;
    mem[4] = 9'b001_000011;
    alu_zero = 1'b1;
    do_reset();
    start = 1'b1;
    wait_done(100);
    chk("beq_taken_pc", pc, 7);
    alu_zero = 1'b0;
    do_reset();
    start = 1'b1;
    wait_done(100);
    chk("beq_not_taken_pc", pc, 5);

    // backward BEQ at pc 0 wraps; zero_q survives a restart from HALT
    clear_mem();
    mem[0] = 9'h010;
    alu_zero = 1'b1;
    do_reset();
    start = 1'b1;
    wait_done(40);
    chk("wrap_pre_pc", pc, 1);
    mem[0] = 9'b001_111110;
    start = 1'b0;
    tick();
    chk("halt_hold_done", done, 1);
    start = 1'b1;
    tick();
    chk("restart_pc", pc, 0);
    chk("restart_done", done, 0);
    wait_done(40);
    chk("wrap_pc", pc, (1 << PC_W) - 2);

    // LBU then SB
    clear_mem();
    mem[0] = 9'h0C4;
    mem[1] = 9'h080;
    do_reset();
    cnt_rwen = 0; cnt_ren = 0; cnt_wen = 0;
    start = 1'b1;
    wait_done(40);
    chk("mem_ren_pulses", cnt_ren, 1);
    chk("mem_wen_pulses", cnt_wen, 1);
    chk("reg_wen_pulses", cnt_rwen, 1);
    chk("mem_halt_pc", pc, 2);

    // HALT at pc 3, held, then restart
    clear_mem();
    mem[0] = 9'h005;
    mem[1] = 9'h106;
    mem[2] = 9'h14B;
    do_reset();
    start = 1'b1;
    wait_done(40);
    chk("halt_pc", pc, 3);
`ifdef CTRL_ICOUNT_EN
    chk("halt_icount", icount, 4);
`endif
    tick(); tick();
    chk("halt_pc_held", pc, 3);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("restart2_pc", pc, 0);
    chk("restart2_done", done, 0);

    // randomized programs, flags, start and occasional reset
    for (int i = 0; i < (1 << PC_W); i++) begin
      logic [31:0] r;
      r = $urandom;
      mem[i] = (r[31:28] == 4'h0) ? {5'b00011, r[3:0]} : r[8:0];
    end
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      alu_zero = 1'($urandom_range(0, 1));
      alu_sc   = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
